// File: rtl/down_timer.sv
// down_timer: programmable N-bit down-counting timer with one-shot and
// periodic (auto-reload) modes. It loads a start value and decrements once
// per cycle with `en` high while running. It marks expiry with a registered
// one-cycle `done` pulse.
module down_timer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         periodic,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] r_q, r_d;       // reload value, latched on start
  logic         mode_q, mode_d; // 1 = periodic, 0 = one-shot
  logic         done_q, done_d;

  // Next-state logic: stop beats start, and start beats en.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    if (stop) begin
      // Abort: q freezes where it is and no done is produced.
      state_d = IDLE;
    end else if (start) begin
      if (load_val == '0) begin
        // A zero period expires at once and never auto-reloads.
        q_d     = '0;
        r_d     = '0;
        mode_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        q_d     = load_val;
        r_d     = load_val;
        mode_d  = periodic;
        state_d = RUN;
      end
    end else if (state_q == RUN && en) begin
      if (q_q == N'(1)) begin
        done_d = 1'b1;
        if (mode_q) begin
          q_d = r_q;
        end else begin
          q_d     = '0;
          state_d = IDLE;
        end
      end else if (q_q != '0) begin
        q_d = q_q - N'(1);
      end
    end
  end

  // State, count, reload and done registers; reset is asynchronous and takes effect mid-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign zero = (q_q == '0);

endmodule

// File: doc/down_timer.md
# down_timer

Programmable N-bit down-counting timer, the counterpart of the free-running up counter. It loads a start value, decrements on each qualified enable and signals expiry with a registered one-cycle `done` pulse. It runs in one-shot or periodic (auto-reload) mode. It sits beside the up counter as the timeout and interval generator for sequential blocks; a prescaler tick drives its `en`.

## Interface
- `N`, default 8: counter and load width in bits.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  load `load_val` and begin counting; also restarts a running count.
- `stop`  in  1  abort the count; `q` freezes.
- `en`  in  1  count enable: one decrement per cycle with `en`=1 while running.
- `periodic`  in  1  sampled at `start`: 1 = auto-reload, 0 = one-shot.
- `load_val`  in  N  start and reload value, latched on `start` only.
- `q`  out  N  current count, registered.
- `busy`  out  1  high while in RUN, registered.
- `done`  out  1  one-cycle expiry pulse, registered.
- `zero`  out  1  combinational, equals (`q` == 0).

## Operation
- States: IDLE and RUN.
  - `done` is a separate registered flag, not a state.
- Reset values: `q`=0, reload register R=0, mode=one-shot, state=IDLE, `busy`=0, `done`=0, so `zero`=1.
- Priority each cycle: `stop` > `start` > `en`.
- IDLE:
  - `q` holds and `en` is ignored.
  - On `start` with `load_val`≠0: R←`load_val`, mode←`periodic`, `q`←`load_val`, go to RUN.
- `start` with `load_val`=0, in any state:
  - `q`←0 and `done`←1 for one cycle.
  - State←IDLE and `periodic` is ignored.
  - A zero period never auto-reloads.
- RUN, with `en`=1 and `q`>1: `q`←`q`−1.
- RUN, with `en`=1 and `q`=1 (terminal):
  - One-shot: `q`←0, `done`←1, go to IDLE.
  - Periodic: `q`←R, `done`←1, stay in RUN. `q` never shows 0 in periodic mode.
- RUN with `stop`: go to IDLE, `q` holds its value, no `done`. `start` resumes from `load_val`, not from the held value.
- RUN with `start`: restart from the new `load_val` and mode.
  - A coinciding terminal decrement is discarded and produces no `done`.
- `stop` together with a terminal decrement: `stop` wins and no `done` is produced.
- `load_val` and `periodic` changes during RUN have no effect until the next `start`.
- Arithmetic:
  - `q` never wraps below 0 and never exceeds 2^N−1.
  - Period equals R `en`-qualified cycles.

## Timing
- `start` sampled at edge k: `q`=`load_val` and `busy`=1 from edge k.
- First decrement is at edge k+1 if `en`=1. `start` and `en` in the same cycle do not decrement.
- `done` rises at the same edge that makes `q` terminal and is low on the next edge.
  - One-shot: `done` is high in the first cycle with `q`=0, and `busy` falls at the same edge.
  - Periodic: `done` rises at the reload edge.
- With `en` tied high, one-shot `done` appears at edge k+`load_val`; periodic `done` repeats every R cycles.
- Asynchronous reset takes effect immediately mid-count. `done` is never emitted for an interrupted count.

## Structure
- Two state encodings, IDLE=0 and RUN=1, as local constants inside the module.
- No shared-package content: nothing is reused by other blocks.
- No sub-module: counter, reload register and control fit in one module. The prescaler feeding `en` stays external.

## Test plan
- Reset: assert `rst` mid-RUN with `q`=5 → `q`=0, `busy`=0, `done`=0, `zero`=1 immediately. No `done` after release.
- One-shot, N=8, `load_val`=3, `en`=1: `start` at edge k → `q`=3,2,1,0 at edges k..k+3. `done`=1 only after edge k+3. `busy` falls at edge k+3.
- Periodic, `load_val`=4, `en`=1: `q`=4,3,2,1,4,3,… `done` pulses every 4 cycles. `busy` stays 1 and `zero` stays 0.
- Gated enable, `load_val`=2, `en` high one cycle in three: `q` changes only on `en` cycles. `done` follows the 2nd `en` pulse; `q` holds between pulses.
- Abort and restart: `load_val`=10, `stop` when `q`=5 → `q` holds 5, `busy`=0, no `done`. Then `start` with 7 → `q`=7.
- Corner cases:
  - `start` with `load_val`=0 → single `done`, `busy`=0, `q`=0.
  - `start`(load 9) on a one-shot terminal cycle (`q`=1, `en`=1) → `q`=9, `busy`=1, no `done`.
  - 255 with N=8 counts 255 cycles without wrap.
